// File: rtl/butterfly_feeder_if.sv
// Sample-in / pair-out bundle between a natural-order sample source and butterfly_feeder.
// Also declares complex_product_t, the shared complex sample type.
typedef struct packed {
    logic signed [15:0] r;
    logic signed [15:0] i;
} complex_product_t;

interface butterfly_feeder_if #(
    parameter int N    = 64,
    parameter int TW_W = 16
);
    logic                   in_valid;
    logic                   in_sop;
    complex_product_t       in_data;
    logic                   out_valid;
    complex_product_t       out_A;
    complex_product_t       out_B;
    logic signed [TW_W-1:0] out_W_R;
    logic signed [TW_W-1:0] out_W_I;
    logic [$clog2(N)-2:0]   out_idx;
    logic                   out_last;
    logic                   frame_err;

    modport master (
        output in_valid, in_sop, in_data,
        input  out_valid, out_A, out_B, out_W_R, out_W_I, out_idx, out_last, frame_err
    );

    modport slave (
        input  in_valid, in_sop, in_data,
        output out_valid, out_A, out_B, out_W_R, out_W_I, out_idx, out_last, frame_err
    );
endinterface

// File: rtl/butterfly_feeder.sv
// Radix-2 DIF feeder: buffers the first half of each frame and pairs sample k with k+N/2 plus twiddle W_N^k.
// Optional BUTTERFLY_FEEDER_SOP_CHECK_EN realigns on in_sop and flags misaligned frames on frame_err.
module butterfly_feeder #(
    parameter int N       = 64,
    parameter int TW_W    = 16,
    parameter int TW_FRAC = 14
) (
    input logic              clk,
    input logic              reset,
    butterfly_feeder_if.slave bus
);
    localparam int LOGN = $clog2(N);
    localparam int KW   = LOGN - 1;
    localparam int HALF = N / 2;
    localparam logic [KW-1:0] K_LAST = KW'(HALF - 1);

    typedef enum logic {FILL = 1'b0, PAIR = 1'b1} phase_t;

    function automatic int roundAway(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        else          return -$rtoi(0.5 - x);
    endfunction

    // Entry k packs {cos, -sin} of 2*pi*k/N scaled by 2^TW_FRAC.
    function automatic logic [HALF*2*TW_W-1:0] makeTwiddles();
        logic [HALF*2*TW_W-1:0] tblV;
        logic signed [TW_W-1:0] wr;
        logic signed [TW_W-1:0] wi;
        real                    angle;
        real                    scale;
        tblV  = '0;
        scale = 2.0 ** TW_FRAC;
        for (int k = 0; k < HALF; k++) begin
            angle = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
            wr    = TW_W'(roundAway($cos(angle) * scale));
            wi    = TW_W'(roundAway(-$sin(angle) * scale));
            tblV[k*2*TW_W +: 2*TW_W] = {wr, wi};
        end
        return tblV;
    endfunction

    localparam logic [HALF*2*TW_W-1:0] TW_TABLE = makeTwiddles();

    logic [LOGN-1:0]        r_cnt;
    complex_product_t       r_buf [HALF];
    logic                   r_valid;
    complex_product_t       r_a;
    complex_product_t       r_b;
    logic signed [TW_W-1:0] r_wr;
    logic signed [TW_W-1:0] r_wi;
    logic [KW-1:0]          r_idx;
    logic                   r_last;
    logic                   r_frameErr;

    logic                   w_restart;
    logic                   w_err;
    logic [LOGN-1:0]        w_effCnt;
    logic [KW-1:0]          w_k;
    phase_t                 w_phase;
    logic [2*TW_W-1:0]      w_tw;

`ifdef BUTTERFLY_FEEDER_SOP_CHECK_EN
    // A mid-frame sop restarts the frame at this sample; a frame start without sop is flagged but kept.
    assign w_restart = bus.in_sop && (r_cnt != '0);
    assign w_err     = bus.in_valid && (bus.in_sop ? (r_cnt != '0) : (r_cnt == '0));
`else
    logic w_unusedSop;
    assign w_unusedSop = bus.in_sop;
    assign w_restart   = 1'b0;
    assign w_err       = 1'b0;
`endif

    assign w_effCnt = w_restart ? '0 : r_cnt;
    assign w_phase  = phase_t'(w_effCnt[LOGN-1]);
    assign w_k      = w_effCnt[KW-1:0];
    assign w_tw     = TW_TABLE[int'(w_k)*2*TW_W +: 2*TW_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (bus.in_valid) begin
            r_cnt <= w_effCnt + 1'b1;
        end
    end

    // No reset: stale first-half samples are always overwritten before a PAIR reads them.
    always_ff @(posedge clk) begin
        if (bus.in_valid && (w_phase == FILL)) begin
            r_buf[w_k] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_wr       <= '0;
            r_wi       <= '0;
            r_idx      <= '0;
            r_last     <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_frameErr <= w_err;
            r_valid    <= bus.in_valid && (w_phase == PAIR);
            if (bus.in_valid && (w_phase == PAIR)) begin
                r_a    <= r_buf[w_k];
                r_b    <= bus.in_data;
                r_wr   <= w_tw[2*TW_W-1:TW_W];
                r_wi   <= w_tw[TW_W-1:0];
                r_idx  <= w_k;
                r_last <= (w_k == K_LAST);
            end
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.out_A     = r_a;
    assign bus.out_B     = r_b;
    assign bus.out_W_R   = r_wr;
    assign bus.out_W_I   = r_wi;
    assign bus.out_idx   = r_idx;
    assign bus.out_last  = r_last;
    assign bus.frame_err = r_frameErr;
endmodule

// File: tb/tb_butterfly_feeder.sv
// Scoreboard bench for butterfly_feeder: N=8 pairing/gaps/reset/sop cases and N=64 twiddle sweep.
module tb_butterfly_feeder;
    typedef struct {
        int ar; int ai; int br; int bi;
        int wr; int wi; int idx; bit last; int due;
    } pair_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    butterfly_feeder_if #(.N(8),  .TW_W(16)) bus8();
    butterfly_feeder_if #(.N(64), .TW_W(16)) bus64();

    butterfly_feeder #(.N(8),  .TW_W(16), .TW_FRAC(14)) dut8  (.clk(clk), .reset(reset), .bus(bus8));
    butterfly_feeder #(.N(64), .TW_W(16), .TW_FRAC(14)) dut64 (.clk(clk), .reset(reset), .bus(bus64));

    int    assertCount = 0;
    int    failCount   = 0;
    int    negCount    = 0;
    int    errDue      = -1;
    pair_t q8[$];
    pair_t q64[$];
    int    mCnt [2];
    int    mBufR[2][32];
    int    mBufI[2][32];
    int    tw8R [4] = '{16384, 11585, 0, -11585};
    int    tw8I [4] = '{0, -11585, -16384, -11585};

    task automatic checkOutput(input string tag, input int obs, input int exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        else          return -$rtoi(0.5 - x);
    endfunction

    function automatic int expTw(input int sel, input int k, input bit imag);
        real a;
        a = 2.0 * 3.14159265358979323846 * real'(k) / 64.0;
        if (sel == 0) return imag ? tw8I[k] : tw8R[k];
        return imag ? rnd(-$sin(a) * 16384.0) : rnd($cos(a) * 16384.0);
    endfunction

    // Reference behaviour of one accepted sample: buffer, pair, or flag misalignment.
    task automatic modelAccept(input int sel, input bit sop, input int re, input int im);
        int    half;
        pair_t p;
        half = (sel == 0) ? 4 : 32;
`ifdef BUTTERFLY_FEEDER_SOP_CHECK_EN
        if (sel == 0) begin
            if (sop && mCnt[0] != 0) begin
                errDue  = negCount + 1;
                mCnt[0] = 0;
            end else if (!sop && mCnt[0] == 0) begin
                errDue = negCount + 1;
            end
        end
`else
        if (sop) p.last = 1'b0;
`endif
        if (mCnt[sel] < half) begin
            mBufR[sel][mCnt[sel]] = re;
            mBufI[sel][mCnt[sel]] = im;
        end else begin
            p.idx  = mCnt[sel] - half;
            p.ar   = mBufR[sel][p.idx];
            p.ai   = mBufI[sel][p.idx];
            p.br   = re;
            p.bi   = im;
            p.wr   = expTw(sel, p.idx, 1'b0);
            p.wi   = expTw(sel, p.idx, 1'b1);
            p.last = (p.idx == half - 1);
            p.due  = negCount + 1;
            if (sel == 0) q8.push_back(p);
            else          q64.push_back(p);
        end
        mCnt[sel] = (mCnt[sel] + 1) % (2 * half);
    endtask

    task automatic applyStimulus(input int sel, input bit v, input bit sop, input int re, input int im);
        @(negedge clk);
        #1;
        bus8.in_valid     = (sel == 0) && v;
        bus8.in_sop       = sop;
        bus8.in_data.r    = 16'(re);
        bus8.in_data.i    = 16'(im);
        bus64.in_valid    = (sel == 1) && v;
        bus64.in_sop      = sop;
        bus64.in_data.r   = 16'(re);
        bus64.in_data.i   = 16'(im);
        if (v) modelAccept(sel, sop, re, im);
    endtask

    task automatic scorePair(input int sel, input bit v, input int ar, input int ai, input int br,
                             input int bi, input int wr, input int wi, input int idx, input bit last);
        pair_t p;
        bit    due;
        while ((sel == 0 && q8.size() > 0 && q8[0].due < negCount) ||
               (sel == 1 && q64.size() > 0 && q64[0].due < negCount)) begin
            checkOutput("missedPair", 0, 1);
            if (sel == 0) void'(q8.pop_front());
            else          void'(q64.pop_front());
        end
        due = (sel == 0) ? (q8.size() > 0 && q8[0].due == negCount)
                         : (q64.size() > 0 && q64[0].due == negCount);
        if (due) begin
            p = (sel == 0) ? q8.pop_front() : q64.pop_front();
            checkOutput("outValid", int'(v), 1);
            checkOutput("outA.r", ar, p.ar);
            checkOutput("outA.i", ai, p.ai);
            checkOutput("outB.r", br, p.br);
            checkOutput("outB.i", bi, p.bi);
            checkOutput("outW_R", wr, p.wr);
            checkOutput("outW_I", wi, p.wi);
            checkOutput("outIdx", idx, p.idx);
            checkOutput("outLast", int'(last), int'(p.last));
            if (sel == 1 && p.idx == 8) begin
                checkOutput("w8R", wr, 11585);
                checkOutput("w8I", wi, -11585);
            end
        end else if (v) begin
            checkOutput("unexpectedValid", 1, 0);
        end
    endtask

    // Samples outputs half a cycle after each active edge.
    always @(negedge clk) begin
        negCount++;
        if (reset) begin
            checkOutput("rstValid", int'(bus8.out_valid), 0);
            checkOutput("rstA", int'(bus8.out_A), 0);
            checkOutput("rstB", int'(bus8.out_B), 0);
            checkOutput("rstWR", int'(bus8.out_W_R), 0);
            checkOutput("rstWI", int'(bus8.out_W_I), 0);
            checkOutput("rstIdx", int'(bus8.out_idx), 0);
            checkOutput("rstLast", int'(bus8.out_last), 0);
            checkOutput("rstErr", int'(bus8.frame_err), 0);
            checkOutput("rstValid64", int'(bus64.out_valid), 0);
        end else begin
            checkOutput("frameErr", int'(bus8.frame_err), int'(negCount == errDue));
            scorePair(0, bus8.out_valid, $signed(bus8.out_A.r), $signed(bus8.out_A.i),
                      $signed(bus8.out_B.r), $signed(bus8.out_B.i), $signed(bus8.out_W_R),
                      $signed(bus8.out_W_I), int'(bus8.out_idx), bus8.out_last);
            scorePair(1, bus64.out_valid, $signed(bus64.out_A.r), $signed(bus64.out_A.i),
                      $signed(bus64.out_B.r), $signed(bus64.out_B.i), $signed(bus64.out_W_R),
                      $signed(bus64.out_W_I), int'(bus64.out_idx), bus64.out_last);
        end
    end

    task automatic pulseReset();
        @(negedge clk);
        #1;
        reset          = 1'b1;
        bus8.in_valid  = 1'b0;
        bus64.in_valid = 1'b0;
        mCnt[0]        = 0;
        mCnt[1]        = 0;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bus8.in_valid  = 1'b0;
        bus8.in_sop    = 1'b0;
        bus8.in_data   = '0;
        bus64.in_valid = 1'b0;
        bus64.in_sop   = 1'b0;
        bus64.in_data  = '0;
        mCnt[0] = 0;
        mCnt[1] = 0;
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;

        $display("[TB] contiguous frames 1..8 and 11..18");
        for (int p = 0; p < 8; p++) applyStimulus(0, 1'b1, p == 0, p + 1, 0);
        for (int p = 0; p < 8; p++) applyStimulus(0, 1'b1, p == 0, p + 11, 0);

        $display("[TB] gapped frame 1..8");
        for (int p = 0; p < 8; p++) begin
            applyStimulus(0, 1'b1, p == 0, p + 1, 0);
            applyStimulus(0, 1'b0, 1'b0, 99, 99);
        end

        $display("[TB] reset after six samples, then frame 21..28");
        for (int p = 0; p < 6; p++) applyStimulus(0, 1'b1, p == 0, p + 41, -p);
        pulseReset();
        for (int p = 0; p < 8; p++) applyStimulus(0, 1'b1, p == 0, p + 21, 0);

        $display("[TB] sop at sample 3");
        for (int p = 0; p < 3; p++) applyStimulus(0, 1'b1, p == 0, p + 51, 0);
        for (int p = 0; p < 8; p++) applyStimulus(0, 1'b1, p == 0, p + 61, p);
        applyStimulus(0, 1'b0, 1'b0, 0, 0);
        pulseReset();

        $display("[TB] N=64 complex ramp");
        for (int p = 0; p < 64; p++) applyStimulus(1, 1'b1, p == 0, p * 100 - 3000, 1000 - p * 37);
        repeat (5) applyStimulus(1, 1'b0, 1'b0, 0, 0);

        @(negedge clk);
        #1;
        checkOutput("drain8", q8.size(), 0);
        checkOutput("drain64", q64.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
